// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the 16-bit datapath: fetch over a req/ack memory port,
// decode, execute, memory and write-back phases with sticky halt/error reporting.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    input  logic        zero,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic [15:0] ir,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [2:0]  alu_op,
    output logic        alu_src_imm,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] TMO     = CNT_W'(MEM_TIMEOUT);
    localparam logic [2:0]       ALU_ADD = 3'b000;
    localparam logic [2:0]       ALU_SUB = 3'b001;

    state_t           state;
    logic [15:0]      ir_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       opcode;

    logic op_rtype, op_addi, op_lw, op_sw, op_beq, op_bne, op_jr, op_halt, op_legal;

    assign opcode   = ir_q[15:12];
    assign op_rtype = (opcode <= 4'h4);
    assign op_addi  = (opcode == 4'h5);
    assign op_lw    = (opcode == 4'h8);
    assign op_sw    = (opcode == 4'h9);
    assign op_beq   = (opcode == 4'hC);
    assign op_bne   = (opcode == 4'hD);
    assign op_jr    = (opcode == 4'hE);
    assign op_halt  = (opcode == 4'hF);
    assign op_legal = op_rtype | op_addi | op_lw | op_sw | op_beq | op_bne | op_jr | op_halt;

    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    // Counter is zeroed in every non-request state, which equals clearing on entry to FETCH/MEM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_FETCH;
            ir_q  <= '0;
            cnt   <= '0;
        end else begin
            cnt <= '0;
            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir_q  <= mem_rdata;
                        state <= S_DECODE;
                    end else if (cnt == TMO) begin
                        state <= S_ERR;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_DECODE: begin
                    if (op_halt)       state <= S_HALT;
                    else if (!op_legal) state <= S_ERR;
                    else               state <= S_EXEC;
                end
                S_EXEC: begin
                    if (op_lw || op_sw)          state <= S_MEM;
                    else if (op_rtype || op_addi) state <= S_WB;
                    else                          state <= S_FETCH;
                end
                S_MEM: begin
                    if (mem_ack) begin
                        state <= op_sw ? S_FETCH : S_WB;
                    end else if (cnt == TMO) begin
                        state <= S_ERR;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_WB:    state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                S_ERR:   state <= S_ERR;
                default: state <= S_ERR;
            endcase
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        ir          = '0;
        pc_we       = 1'b0;
        pc_src      = 2'd0;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 2'd0;
        halted      = 1'b0;
        err         = 1'b0;
        if (rst) begin
            ir = ir_q;
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    pc_we   = mem_ack;
                end
                S_EXEC: begin
                    if (op_rtype) begin
                        alu_op = opcode[2:0];
                    end else if (op_addi || op_lw || op_sw) begin
                        alu_src_imm = 1'b1;
                    end else if (op_beq || op_bne) begin
                        alu_op = ALU_SUB;
                        if (op_beq ? zero : !zero) begin
                            pc_we  = 1'b1;
                            pc_src = 2'd1;
                        end
                    end else if (op_jr) begin
                        pc_we  = 1'b1;
                        pc_src = 2'd2;
                    end
                end
                S_MEM: begin
                    mem_req     = 1'b1;
                    addr_sel    = 1'b1;
                    alu_src_imm = 1'b1;
                    mem_we      = op_sw;
                end
                S_WB: begin
                    reg_we = 1'b1;
                    wb_sel = op_lw ? 2'd1 : 2'd0;
                end
                S_HALT:  halted = 1'b1;
                S_ERR:   err    = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl: stimulus builds each instruction's
// expected per-cycle control vector from the opcode rules; a negedge monitor compares.
module tb_multicycle_ctrl;

    localparam int unsigned TMO = 4;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic        addr_sel;
        logic [15:0] ir;
        logic        pc_we;
        logic [1:0]  pc_src;
        logic [2:0]  alu_op;
        logic        alu_src_imm;
        logic        reg_we;
        logic [1:0]  wb_sel;
        logic        halted;
        logic        err;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        zero = 1'b0;
    logic        mem_req, mem_we, addr_sel, pc_we, alu_src_imm, reg_we, halted, err;
    logic [15:0] ir;
    logic [1:0]  pc_src, wb_sel;
    logic [2:0]  alu_op;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .zero(zero),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir(ir),
        .pc_we(pc_we), .pc_src(pc_src), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
        .reg_we(reg_we), .wb_sel(wb_sel), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    out_t        exp_q[$];
    string       tag_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] cur_ir = '0;

    // Monitor: one expected control vector per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        out_t  act;
        out_t  e;
        string t;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            act = {mem_req, mem_we, addr_sel, ir, pc_we, pc_src, alu_op,
                   alu_src_imm, reg_we, wb_sel, halted, err};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s @%0t: got req=%b we=%b as=%b ir=%h pcwe=%b pcsrc=%0d alu=%0d imm=%b rwe=%b wb=%0d h=%b e=%b required req=%b we=%b as=%b ir=%h pcwe=%b pcsrc=%0d alu=%0d imm=%b rwe=%b wb=%0d h=%b e=%b",
                         t, $time, act.mem_req, act.mem_we, act.addr_sel, act.ir, act.pc_we,
                         act.pc_src, act.alu_op, act.alu_src_imm, act.reg_we, act.wb_sel,
                         act.halted, act.err, e.mem_req, e.mem_we, e.addr_sel, e.ir, e.pc_we,
                         e.pc_src, e.alu_op, e.alu_src_imm, e.reg_we, e.wb_sel, e.halted, e.err);
            end
        end
    end

    function automatic out_t base();
        out_t e;
        e    = '0;
        e.ir = cur_ir;
        return e;
    endfunction

    task automatic cyc(input logic r, input logic [15:0] rd, input logic ack,
                       input logic z, input out_t e, input string tag);
        @(posedge clk);
        #1;
        rst       = r;
        mem_rdata = rd;
        mem_ack   = ack;
        zero      = z;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [15:0] rw();
        return 16'($urandom);
    endfunction

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, rw(), rb(), rb(), out_t'('0), "reset");
        cur_ir = '0;
    endtask

    task automatic terminal(input int n, input logic is_halt);
        out_t e;
        for (int i = 0; i < n; i++) begin
            e = base();
            if (is_halt) e.halted = 1'b1;
            else         e.err    = 1'b1;
            cyc(1'b1, rw(), rb(), rb(), e, is_halt ? "halted" : "error");
        end
    endtask

    // result: 0 = back to fetch, 1 = halted, 2 = error, 3 = reset applied in MEM
    task automatic run_instr(input logic [15:0] instr, input int fwait, input int mwait,
                             input logic z, input bit rst_in_mem, output int result);
        out_t       e;
        logic [3:0] op;
        logic       taken;
        result = 0;
        op     = instr[15:12];
        for (int i = 0; i < fwait && i <= int'(TMO); i++) begin
            e = base(); e.mem_req = 1'b1;
            cyc(1'b1, rw(), 1'b0, rb(), e, "fetch_wait");
        end
        if (fwait > int'(TMO)) begin result = 2; return; end
        e = base(); e.mem_req = 1'b1; e.pc_we = 1'b1;
        cyc(1'b1, instr, 1'b1, rb(), e, "fetch_ack");
        cur_ir = instr;
        e = base();
        cyc(1'b1, rw(), rb(), rb(), e, "decode");
        if (op == 4'hF) begin result = 1; return; end
        if (op inside {4'h6, 4'h7, 4'hA, 4'hB}) begin result = 2; return; end
        e = base();
        if (op <= 4'h4) e.alu_op = op[2:0];
        else if (op inside {4'h5, 4'h8, 4'h9}) e.alu_src_imm = 1'b1;
        else if (op inside {4'hC, 4'hD}) begin
            e.alu_op = 3'b001;
            taken    = (op == 4'hC) ? z : !z;
            e.pc_we  = taken;
            e.pc_src = taken ? 2'd1 : 2'd0;
        end else begin
            e.pc_we = 1'b1; e.pc_src = 2'd2;
        end
        cyc(1'b1, rw(), rb(), z, e, "exec");
        if (op inside {4'h8, 4'h9}) begin
            e = base();
            e.mem_req = 1'b1; e.addr_sel = 1'b1; e.alu_src_imm = 1'b1;
            e.mem_we  = (op == 4'h9);
            if (rst_in_mem) begin
                cyc(1'b0, rw(), 1'b1, rb(), out_t'('0), "rst_in_mem");
                cur_ir = '0;
                result = 3;
                return;
            end
            for (int i = 0; i < mwait && i <= int'(TMO); i++)
                cyc(1'b1, rw(), 1'b0, rb(), e, "mem_wait");
            if (mwait > int'(TMO)) begin result = 2; return; end
            cyc(1'b1, rw(), 1'b1, rb(), e, "mem_ack");
        end
        if (op <= 4'h5 || op == 4'h8) begin
            e = base(); e.reg_we = 1'b1; e.wb_sel = (op == 4'h8) ? 2'd1 : 2'd0;
            cyc(1'b1, rw(), rb(), rb(), e, "wb");
        end
    endtask

    task automatic expect_result(input int got, input int want, input string tag);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: model path %0d required %0d", tag, got, want);
        end
    endtask

    logic [3:0] legal_ops[11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE};

    initial begin
        int res;
        logic [15:0] instr;
        do_reset(2);
        run_instr(16'h0123, 0, 0, 1'b0, 1'b0, res);
        run_instr(16'h8127, 0, 3, 1'b0, 1'b0, res);
        run_instr(16'hC12F, 0, 0, 1'b1, 1'b0, res);
        run_instr(16'hC12F, 1, 0, 1'b0, 1'b0, res);
        run_instr(16'hD3A1, 0, 0, 1'b0, 1'b0, res);
        run_instr(16'hD3A1, 0, 0, 1'b1, 1'b0, res);
        run_instr(16'hE400, 2, 0, 1'b0, 1'b0, res);
        run_instr(16'h9127, 0, 2, 1'b0, 1'b0, res);
        run_instr(16'h512F, 0, 0, 1'b0, 1'b0, res);
        run_instr(16'h4567, TMO, 0, 1'b0, 1'b0, res);
        run_instr(16'h8ABC, 1, TMO, 1'b0, 1'b0, res);
        for (int n = 0; n < 60; n++) begin
            instr = {legal_ops[$urandom_range(0, 10)], 12'($urandom)};
            run_instr(instr, $urandom_range(0, TMO), $urandom_range(0, TMO), rb(), 1'b0, res);
        end
        run_instr(16'hA000, 0, 0, 1'b0, 1'b0, res);
        expect_result(res, 2, "illegal_opcode_path");
        terminal(4, 1'b0);
        do_reset(1);
        run_instr(16'h0000, TMO + 1, 0, 1'b0, 1'b0, res);
        terminal(4, 1'b0);
        do_reset(1);
        run_instr(16'h8001, 0, TMO + 1, 1'b0, 1'b0, res);
        terminal(3, 1'b0);
        do_reset(2);
        run_instr(16'h8127, 0, 0, 1'b0, 1'b1, res);
        run_instr(16'h1234, 0, 0, 1'b0, 1'b0, res);
        run_instr(16'h7FFF, 1, 0, 1'b0, 1'b0, res);
        terminal(2, 1'b0);
        do_reset(1);
        run_instr(16'hF000, 0, 0, 1'b0, 1'b0, res);
        expect_result(res, 1, "halt_path");
        terminal(5, 1'b1);
        do_reset(1);
        run_instr(16'h2345, 0, 0, 1'b0, 1'b0, res);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
